// File: rtl/sm4_ck_seq.sv
// SM4 key-schedule CK constant stream generator with forward/reverse order and LANES per beat.
// Define SM4_CK_ROM_EN to source constants from a 64-entry table instead of the byte adders.
module sm4_ck_seq #(
  parameter int unsigned NUM_ROUNDS = 32,
  parameter int unsigned LANES      = 1,
  parameter int unsigned RND_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  dir_i,
  input  logic                  ck_ready_i,
  output logic [32*LANES-1:0]   ck_o,
  output logic                  ck_valid_o,
  output logic [RND_W-1:0]      round_o,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [RND_W-1:0] LastFwd  = RND_W'(NUM_ROUNDS - LANES);
  localparam logic [RND_W-1:0] LastRev  = RND_W'(LANES - 1);
  localparam logic [RND_W-1:0] TopRound = RND_W'(NUM_ROUNDS - 1);
  localparam logic [RND_W-1:0] Step     = RND_W'(LANES);
  localparam logic [7:0]       TopByte  = 8'((28 * (NUM_ROUNDS - 1)) % 256);
  localparam logic [7:0]       StepByte = 8'((28 * LANES) % 256);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                r_state, w_state_d;
  logic [RND_W-1:0]      r_base, w_base_d;
  logic [7:0]            r_base_byte, w_byte_d;
  logic                  r_dir, w_dir_d;
  logic [32*LANES-1:0]   r_ck, w_ck_d;
  logic                  r_done, w_done_d;
  logic                  w_load, w_accept, w_last;

  function automatic logic [31:0] ck_word(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd7;
    b2 = b + 8'd14;
    b3 = b + 8'd21;
    return {b, b1, b2, b3};
  endfunction

  assign w_accept = (r_state == StRun) && ck_ready_i;
  assign w_last   = (r_state == StRun) && (r_dir ? (r_base == LastRev) : (r_base == LastFwd));

  always_comb begin
    w_state_d = r_state;
    w_base_d  = r_base;
    w_byte_d  = r_base_byte;
    w_dir_d   = r_dir;
    w_done_d  = 1'b0;
    w_load    = 1'b0;
    // A start discards whatever beat is on the bus, even if it is being accepted.
    if (start_i) begin
      w_state_d = StRun;
      w_dir_d   = dir_i;
      w_base_d  = dir_i ? TopRound : '0;
      w_byte_d  = dir_i ? TopByte : 8'd0;
      w_load    = 1'b1;
    end else if (w_accept) begin
      if (w_last) begin
        w_state_d = StIdle;
        w_done_d  = 1'b1;
      end else begin
        w_base_d = r_dir ? (r_base - Step) : (r_base + Step);
        w_byte_d = r_dir ? (r_base_byte - StepByte) : (r_base_byte + StepByte);
        w_load   = 1'b1;
      end
    end
  end

`ifdef SM4_CK_ROM_EN
  logic [31:0] w_rom [64];

  always_comb begin
    for (int r = 0; r < 64; r++) begin
      w_rom[r] = ck_word(8'(28 * r));
    end
  end

  always_comb begin
    w_ck_d = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      w_ck_d[32*k +: 32] = w_rom[6'(w_dir_d ? (int'(w_base_d) - k) : (int'(w_base_d) + k))];
    end
  end
`else
  always_comb begin
    w_ck_d = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      w_ck_d[32*k +: 32] = ck_word(w_dir_d ? (w_byte_d - 8'(28 * k)) : (w_byte_d + 8'(28 * k)));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_base_byte <= 8'd0;
      r_dir       <= 1'b0;
      r_ck        <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_base      <= w_base_d;
      r_base_byte <= w_byte_d;
      r_dir       <= w_dir_d;
      r_done      <= w_done_d;
      if (w_load) begin
        r_ck <= w_ck_d;
      end
    end
  end

  assign ck_o       = r_ck;
  assign ck_valid_o = (r_state == StRun);
  assign busy_o     = (r_state == StRun);
  assign round_o    = r_base;
  assign last_o     = w_last;
  assign done_o     = r_done;

endmodule

// File: tb/tb_sm4_ck_seq.sv
// Directed bench for sm4_ck_seq: one LANES=1 and one LANES=2 instance on a shared clock/reset.
module tb_sm4_ck_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, dir1, ready1;
  logic [31:0] ck1;
  logic        valid1, last1, busy1, done1;
  logic [5:0]  round1;
  logic        start2, dir2, ready2;
  logic [63:0] ck2;
  logic        valid2, last2, busy2, done2;
  logic [5:0]  round2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm4_ck_seq #(.NUM_ROUNDS(32), .LANES(1), .RND_W(6)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .dir_i(dir1), .ck_ready_i(ready1),
    .ck_o(ck1), .ck_valid_o(valid1), .round_o(round1), .last_o(last1),
    .busy_o(busy1), .done_o(done1)
  );

  sm4_ck_seq #(.NUM_ROUNDS(32), .LANES(2), .RND_W(6)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .dir_i(dir2), .ck_ready_i(ready2),
    .ck_o(ck2), .ck_valid_o(valid2), .round_o(round2), .last_o(last2),
    .busy_o(busy2), .done_o(done2)
  );

  function automatic logic [31:0] ck_ref(input int r);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(28 * r);
    b1 = 8'(28 * r + 7);
    b2 = 8'(28 * r + 14);
    b3 = 8'(28 * r + 21);
    return {b0, b1, b2, b3};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; dir1 = 1'b0; ready1 = 1'b0;
    start2 = 1'b0; dir2 = 1'b0; ready2 = 1'b0;
    step();
    step();
    chk("rst_ck", 64'(ck1), 64'h0);
    chk("rst_valid", 64'(valid1), 64'h0);
    chk("rst_round", 64'(round1), 64'h0);
    chk("rst_last", 64'(last1), 64'h0);
    chk("rst_busy", 64'(busy1), 64'h0);
    chk("rst_done", 64'(done1), 64'h0);
    chk("rst_ck2", ck2, 64'h0);
    rst_n = 1'b1;
    step();
    chk("idle_valid", 64'(valid1), 64'h0);

    // Forward, LANES=1, ready held high
    start1 = 1'b1; dir1 = 1'b0; ready1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("fwd_first_ck", 64'(ck1), 64'h00070e15);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("fwd_ck_%0d", i), 64'(ck1), 64'(ck_ref(i)));
      chk($sformatf("fwd_round_%0d", i), 64'(round1), 64'(i));
      chk($sformatf("fwd_valid_%0d", i), 64'(valid1), 64'h1);
      chk($sformatf("fwd_busy_%0d", i), 64'(busy1), 64'h1);
      chk($sformatf("fwd_last_%0d", i), 64'(last1), 64'(i == 31));
      chk($sformatf("fwd_done_%0d", i), 64'(done1), 64'h0);
      if (i == 31) chk("fwd_last_ck", 64'(ck1), 64'h646b7279);
      step();
    end
    chk("fwd_done_pulse", 64'(done1), 64'h1);
    chk("fwd_end_valid", 64'(valid1), 64'h0);
    chk("fwd_end_busy", 64'(busy1), 64'h0);
    step();
    chk("fwd_done_clear", 64'(done1), 64'h0);
    chk("fwd_hold_ck", 64'(ck1), 64'h646b7279);

    // Reverse, LANES=1
    start1 = 1'b1; dir1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("rev_first_ck", 64'(ck1), 64'h646b7279);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rev_ck_%0d", i), 64'(ck1), 64'(ck_ref(31 - i)));
      chk($sformatf("rev_round_%0d", i), 64'(round1), 64'(31 - i));
      chk($sformatf("rev_last_%0d", i), 64'(last1), 64'(i == 31));
      if (i == 1) chk("rev_second_ck", 64'(ck1), 64'h484f565d);
      if (i == 2) chk("rev_third_ck", 64'(ck1), 64'h2c333a41);
      if (i == 31) chk("rev_last_ck", 64'(ck1), 64'h00070e15);
      step();
    end
    chk("rev_done_pulse", 64'(done1), 64'h1);
    chk("rev_end_valid", 64'(valid1), 64'h0);
    step();
    chk("rev_done_clear", 64'(done1), 64'h0);
    ready1 = 1'b0;

    // Forward, LANES=2
    start2 = 1'b1; dir2 = 1'b0; ready2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("l2_first_ck", ck2, 64'h1c232a31_00070e15);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("l2_ck_%0d", i), ck2, {ck_ref(2 * i + 1), ck_ref(2 * i)});
      chk($sformatf("l2_round_%0d", i), 64'(round2), 64'(2 * i));
      chk($sformatf("l2_last_%0d", i), 64'(last2), 64'(i == 15));
      chk($sformatf("l2_valid_%0d", i), 64'(valid2), 64'h1);
      if (i == 1) chk("l2_second_ck", ck2, 64'h545b6269_383f464d);
      if (i == 15) chk("l2_last_ck", ck2, 64'h646b7279_484f565d);
      step();
    end
    chk("l2_done_pulse", 64'(done2), 64'h1);
    chk("l2_end_valid", 64'(valid2), 64'h0);
    ready2 = 1'b0;

    // Backpressure at round 9
    start1 = 1'b1; dir1 = 1'b0; ready1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (9) step();
    chk("bp_pre_round", 64'(round1), 64'd9);
    chk("bp_pre_ck", 64'(ck1), 64'hfc030a11);
    ready1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp_hold_ck_%0d", c), 64'(ck1), 64'hfc030a11);
      chk($sformatf("bp_hold_round_%0d", c), 64'(round1), 64'd9);
      chk($sformatf("bp_hold_valid_%0d", c), 64'(valid1), 64'h1);
    end
    ready1 = 1'b1;
    step();
    chk("bp_next_ck", 64'(ck1), 64'h181f262d);
    chk("bp_next_round", 64'(round1), 64'd10);

    // Restart in reverse at round 12 with ready high
    step();
    step();
    chk("rs_pre_round", 64'(round1), 64'd12);
    start1 = 1'b1; dir1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("rs_no_done", 64'(done1), 64'h0);
    chk("rs_valid", 64'(valid1), 64'h1);
    chk("rs_round", 64'(round1), 64'd31);
    chk("rs_ck", 64'(ck1), 64'h646b7279);
    step();
    chk("rs_next_round", 64'(round1), 64'd30);
    chk("rs_next_ck", 64'(ck1), 64'h484f565d);
    chk("rs_next_no_done", 64'(done1), 64'h0);

    // Synchronous reset mid-sequence
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_ck", 64'(ck1), 64'h0);
    chk("mr_valid", 64'(valid1), 64'h0);
    chk("mr_round", 64'(round1), 64'h0);
    chk("mr_last", 64'(last1), 64'h0);
    chk("mr_busy", 64'(busy1), 64'h0);
    chk("mr_done", 64'(done1), 64'h0);
    step();
    chk("mr_idle_valid", 64'(valid1), 64'h0);
    start1 = 1'b1; dir1 = 1'b0;
    step();
    start1 = 1'b0;
    chk("mr_restart_valid", 64'(valid1), 64'h1);
    chk("mr_restart_round", 64'(round1), 64'd0);
    chk("mr_restart_ck", 64'(ck1), 64'h00070e15);
    step();
    chk("mr_restart_ck1", 64'(ck1), 64'h1c232a31);
    ready1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
